// File: rtl/aes_seq_pkg.sv
// Shared types and constants for the AES block sequencer.
// Imported by the sequencer top and its block FIFO.
package aes_seq_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      GAP
   } seqState_t;

   localparam int BLK_W         = 128;
   localparam int WORD_W        = 32;
   localparam int WORDS_PER_BLK = 4;

   localparam logic TYPE_DATA = 1'b0;
   localparam logic TYPE_KEY  = 1'b1;

endpackage

// File: rtl/aes_block_fifo.sv
// Small synchronous FIFO holding {type, block} entries.
// Clear wins over a simultaneous push or pop.
module aes_block_fifo
   import aes_seq_pkg::*;
#(
   parameter int WIDTH = BLK_W + 1,
   parameter int DEPTH = 2,
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] pushData,
   input  logic             pop,
   output logic [WIDTH-1:0] popData,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wrPtr;
   logic [AW-1:0]    rdPtr;
   logic             doPush;
   logic             doPop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign doPush  = push && !full && !clear;
   assign doPop   = pop && !empty && !clear;
   assign popData = mem[rdPtr];

   always_ff @(posedge clk) begin
      if (doPush) begin
         mem[wrPtr] <= pushData;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else if (clear) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) begin
            wrPtr <= wrPtr + AW'(1);
         end
         if (doPop) begin
            rdPtr <= rdPtr + AW'(1);
         end
         unique case ({doPush, doPop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/aes_block_sequencer.sv
// Assembles 32-bit words into AES key/data blocks, queues them,
// and issues them to the core as one-cycle load pulses.
module aes_block_sequencer
   import aes_seq_pkg::*;
#(
   parameter int FIFO_DEPTH = 2,
   parameter int CNT_W      = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [WORD_W-1:0] s_data,
   input  logic              s_is_key,
   input  logic              flush,
   output logic [BLK_W-1:0]  aes_in_data,
   output logic              aes_load_key,
   output logic              aes_load_data,
   input  logic              aes_ready,
   output logic [CNT_W-1:0]  blocks_pending,
   output logic              key_loaded,
   output logic              err_no_key
);

   seqState_t        state;
   seqState_t        nextState;
   logic [1:0]       wordCnt;
   logic [95:0]      blkBuf;
   logic             typeBit;
   logic             accept;
   logic             lastWord;
   logic             fifoFull;
   logic             fifoEmpty;
   logic [BLK_W:0]   headEntry;
   logic             headType;
   logic             doIssue;
   logic             doDrop;

   assign s_ready  = !rst && !fifoFull && !flush;
   assign accept   = s_valid && s_ready;
   assign lastWord = (wordCnt == 2'(WORDS_PER_BLK - 1));
   assign headType = headEntry[BLK_W];

   aes_block_fifo #(
      .WIDTH (BLK_W + 1),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) uFifo (
      .clk      (clk),
      .rst      (rst),
      .clear    (flush),
      .push     (accept && lastWord),
      .pushData ({typeBit, blkBuf, s_data}),
      .pop      (doIssue || doDrop),
      .popData  (headEntry),
      .full     (fifoFull),
      .empty    (fifoEmpty),
      .count    (blocks_pending)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wordCnt <= '0;
         blkBuf  <= '0;
         typeBit <= TYPE_DATA;
      end else if (flush) begin
         wordCnt <= '0;
      end else if (accept) begin
         wordCnt <= wordCnt + 2'd1;
         unique case (wordCnt)
            2'd0: begin
               blkBuf[95:64] <= s_data;
               typeBit       <= s_is_key;
            end
            2'd1:    blkBuf[63:32] <= s_data;
            2'd2:    blkBuf[31:0]  <= s_data;
            default: blkBuf        <= blkBuf;
         endcase
      end
   end

   // Data blocks with no key yet are discarded at the head, not issued.
   always_comb begin
      nextState = state;
      doIssue   = 1'b0;
      doDrop    = 1'b0;
      unique case (state)
         IDLE: begin
            if (!fifoEmpty && aes_ready && !flush) begin
               if (headType == TYPE_KEY || key_loaded) begin
                  doIssue   = 1'b1;
                  nextState = ISSUE;
               end else begin
                  doDrop = 1'b1;
               end
            end
         end
         ISSUE:   nextState = GAP;
         GAP:     nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         aes_in_data   <= '0;
         aes_load_key  <= 1'b0;
         aes_load_data <= 1'b0;
         key_loaded    <= 1'b0;
         err_no_key    <= 1'b0;
      end else begin
         state         <= nextState;
         aes_load_key  <= doIssue && (headType == TYPE_KEY);
         aes_load_data <= doIssue && (headType == TYPE_DATA);
         if (doIssue) begin
            aes_in_data <= headEntry[BLK_W-1:0];
         end
         if (doIssue && headType == TYPE_KEY) begin
            key_loaded <= 1'b1;
         end
         if (doDrop) begin
            err_no_key <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_aes_block_sequencer.sv
// Directed bench for aes_block_sequencer with an issue scoreboard.
// A negedge monitor checks every load pulse against queued blocks.
module tb_aes_block_sequencer;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         s_valid = 1'b0;
   logic         s_ready;
   logic [31:0]  s_data = '0;
   logic         s_is_key = 1'b0;
   logic         flush = 1'b0;
   logic [127:0] aes_in_data;
   logic         aes_load_key;
   logic         aes_load_data;
   logic         aes_ready = 1'b0;
   logic [1:0]   blocks_pending;
   logic         key_loaded;
   logic         err_no_key;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int lastPulse = -100;
   int pulseCnt = 0;
   logic [128:0] sbq [$];

   localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] DAT1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] DAT2 = 128'hdeadbeef0123456789abcdeffedcba98;
   localparam logic [127:0] DAT3 = 128'h11111111222222223333333344444444;
   localparam logic [127:0] DAT4 = 128'h55555555666666667777777788888888;
   localparam logic [127:0] KEY2 = 128'hcafef00d0badc0de1357924680aceb0f;
   localparam logic [127:0] DAT5 = 128'ha5a5a5a55a5a5a5a0f0f0f0ff0f0f0f0;

   aes_block_sequencer dut (
      .clk            (clk),
      .rst            (rst),
      .s_valid        (s_valid),
      .s_ready        (s_ready),
      .s_data         (s_data),
      .s_is_key       (s_is_key),
      .flush          (flush),
      .aes_in_data    (aes_in_data),
      .aes_load_key   (aes_load_key),
      .aes_load_data  (aes_load_data),
      .aes_ready      (aes_ready),
      .blocks_pending (blocks_pending),
      .key_loaded     (key_loaded),
      .err_no_key     (err_no_key)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [128:0] obs,
                      input logic [128:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && (aes_load_key || aes_load_data)) begin
         logic [128:0] e;
         pulseCnt++;
         chk("pulse_spacing", 129'(cyc - lastPulse >= 3), 129'(1));
         lastPulse = cyc;
         if (sbq.size() == 0) begin
            chk("unexpected_pulse", {aes_load_key, aes_in_data}, '0);
         end else begin
            e = sbq.pop_front();
            chk("issue_type_key", 129'(aes_load_key), 129'(e[128]));
            chk("issue_type_data", 129'(aes_load_data), 129'(!e[128]));
            chk("issue_block", 129'(aes_in_data), 129'(e[127:0]));
         end
      end
   end

   task automatic sendWord(input logic [31:0] w, input logic k);
      int n;
      @(negedge clk);
      s_valid  = 1'b1;
      s_data   = w;
      s_is_key = k;
      n = 0;
      while (!s_ready && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) begin
         chk("s_ready_timeout", 129'(s_ready), 129'(1));
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0;
   endtask

   task automatic sendBlock(input logic [127:0] b, input logic k,
                            input bit expIssue);
      for (int i = 0; i < 4; i++) begin
         sendWord(b[127 - 32*i -: 32], (i == 0) ? k : !k);
      end
      if (expIssue) sbq.push_back({k, b});
   endtask

   task automatic waitPulse(input int start, input int maxCyc);
      for (int i = 0; i < maxCyc; i++) begin
         if (pulseCnt > start) break;
         @(negedge clk);
      end
      chk("pulse_seen", 129'(pulseCnt > start), 129'(1));
   endtask

   initial begin
      int p0;
      int n;
      logic [127:0] held;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_s_ready", 129'(s_ready), 129'(0));
      chk("rst_pending", 129'(blocks_pending), 129'(0));
      chk("rst_pulses", 129'({aes_load_key, aes_load_data}), 129'(0));
      chk("rst_in_data", 129'(aes_in_data), 129'(0));
      chk("rst_flags", 129'({key_loaded, err_no_key}), 129'(0));
      rst = 1'b0;
      aes_ready = 1'b1;
      @(negedge clk);
      chk("s_ready_after_rst", 129'(s_ready), 129'(1));

      // key path with exact latency and width
      sendBlock(KEY1, 1'b1, 1'b1);
      chk("key_not_yet", 129'(aes_load_key), 129'(0));
      @(posedge clk); #1;
      chk("key_pulse_on", 129'(aes_load_key), 129'(1));
      chk("key_in_data", 129'(aes_in_data), 129'(KEY1));
      @(posedge clk); #1;
      chk("key_pulse_off", 129'(aes_load_key), 129'(0));
      chk("key_loaded", 129'(key_loaded), 129'(1));

      // data after key; s_is_key toggles on words 1..3 are ignored
      p0 = pulseCnt;
      sendBlock(DAT1, 1'b0, 1'b1);
      waitPulse(p0, 10);
      held = aes_in_data;
      chk("data_in_data", 129'(held), 129'(DAT1));
      repeat (6) @(negedge clk);
      chk("data_hold", 129'(aes_in_data), 129'(DAT1));
      chk("no_err", 129'(err_no_key), 129'(0));

      // backpressure
      aes_ready = 1'b0;
      p0 = pulseCnt;
      sendBlock(DAT2, 1'b0, 1'b1);
      sendBlock(DAT3, 1'b0, 1'b1);
      @(negedge clk);
      chk("bp_pending", 129'(blocks_pending), 129'(2));
      s_valid = 1'b1;
      s_data  = DAT4[127:96];
      repeat (3) @(negedge clk);
      chk("bp_s_ready", 129'(s_ready), 129'(0));
      chk("bp_no_pulse", 129'(pulseCnt - p0), 129'(0));
      s_valid = 1'b0;
      aes_ready = 1'b1;
      sendBlock(DAT4, 1'b0, 1'b1);
      n = 0;
      while ((sbq.size() != 0 || blocks_pending != 0) && n < 80) begin
         @(negedge clk);
         n++;
      end
      chk("bp_drained", 129'(sbq.size()), 129'(0));
      chk("bp_pulses", 129'(pulseCnt - p0), 129'(3));
      chk("bp_s_ready_back", 129'(s_ready), 129'(1));

      // no key after reset
      @(negedge clk);
      rst = 1'b1;
      sbq.delete();
      @(negedge clk);
      rst = 1'b0;
      p0 = pulseCnt;
      sendBlock(DAT1, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      chk("nokey_err", 129'(err_no_key), 129'(1));
      chk("nokey_pending", 129'(blocks_pending), 129'(0));
      chk("nokey_no_pulse", 129'(pulseCnt - p0), 129'(0));
      chk("nokey_key_loaded", 129'(key_loaded), 129'(0));
      sendBlock(KEY2, 1'b1, 1'b1);
      waitPulse(p0, 10);
      @(negedge clk);
      chk("nokey_key_ok", 129'(key_loaded), 129'(1));
      chk("nokey_err_sticky", 129'(err_no_key), 129'(1));

      // flush
      repeat (3) @(negedge clk);
      aes_ready = 1'b0;
      sendBlock(DAT2, 1'b0, 1'b1);
      sendWord(DAT3[127:96], 1'b0);
      sendWord(DAT3[95:64], 1'b0);
      @(negedge clk);
      chk("fl_pending_before", 129'(blocks_pending), 129'(1));
      flush   = 1'b1;
      s_valid = 1'b1;
      s_data  = 32'hbadbad00;
      #1;
      chk("fl_s_ready", 129'(s_ready), 129'(0));
      @(negedge clk);
      flush   = 1'b0;
      s_valid = 1'b0;
      sbq.delete();
      chk("fl_pending_after", 129'(blocks_pending), 129'(0));
      chk("fl_flags_kept", 129'({key_loaded, err_no_key}), 129'(3));
      aes_ready = 1'b1;
      p0 = pulseCnt;
      sendBlock(DAT5, 1'b0, 1'b1);
      waitPulse(p0, 10);
      chk("fl_fresh_block", 129'(aes_in_data), 129'(DAT5));
      chk("fl_pulses", 129'(pulseCnt - p0), 129'(1));
      chk("sb_empty", 129'(sbq.size()), 129'(0));

      // async reset during ISSUE
      repeat (4) @(negedge clk);
      sendBlock(KEY1, 1'b1, 1'b1);
      @(posedge clk); #1;
      chk("ar_pulse_pre", 129'(aes_load_key), 129'(1));
      #1;
      rst = 1'b1;
      sbq.delete();
      #1;
      chk("ar_pulse_drop", 129'({aes_load_key, aes_load_data}), 129'(0));
      chk("ar_in_data", 129'(aes_in_data), 129'(0));
      chk("ar_flags", 129'({key_loaded, err_no_key}), 129'(0));
      chk("ar_pending", 129'(blocks_pending), 129'(0));
      chk("ar_s_ready", 129'(s_ready), 129'(0));
      @(negedge clk);
      @(negedge clk);
      chk("ar_s_ready_hold", 129'(s_ready), 129'(0));
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("ar_quiet", 129'({aes_load_key, aes_load_data}), 129'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
